id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register and operand-forwarding stage of the 5-stage RV32I core.
- Latches decoded operands and control from ID, then resolves EX operands through MEM/WB forwarding and the ALUSrc mux.
- Its outputs feed the ALU operands directly, and the ALU control unit through ex_inst and ex_alu_op.
- Also flags load-use hazards to the hazard unit.

---
 rtl/id_ex_operand_stage.sv | 205 ++++++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use detect.
// Optional macro EX_FORWARD_EN enables forwarding and stall refresh.
module id_ex_operand_stage #(
   parameter int          XLEN     = 32,
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            id_valid,
   input  logic [31:0]     id_pc,
   input  logic [31:0]     id_inst,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [1:0]      id_alu_op,
   input  logic            id_alu_src,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic            id_mem_to_reg,
   input  logic            stall,
   input  logic            flush,
   input  logic            mem_reg_write,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_fwd_data,
   input  logic            wb_reg_write,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_write_data,
   output logic            ex_valid,
   output logic [31:0]     ex_pc,
   output logic [31:0]     ex_inst,
   output logic [4:0]      ex_rd,
   output logic [1:0]      ex_alu_op,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_mem_to_reg,
   output logic [XLEN-1:0] ex_alu_in_1,
   output logic [XLEN-1:0] ex_alu_in_2,
   output logic [XLEN-1:0] ex_store_data,
   output logic            load_use_hazard
);

   logic            valid_q, valid_d;
   logic [31:0]     pc_q, pc_d;
   logic [31:0]     inst_q, inst_d;
   logic [4:0]      rs1_q, rs1_d;
   logic [4:0]      rs2_q, rs2_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] rs1_data_q, rs1_data_d;
   logic [XLEN-1:0] rs2_data_q, rs2_data_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic [1:0]      alu_op_q, alu_op_d;
   logic            alu_src_q, alu_src_d;
   logic            reg_write_q, reg_write_d;
   logic            mem_read_q, mem_read_d;
   logic            mem_write_q, mem_write_d;
   logic            mem_to_reg_q, mem_to_reg_d;
   logic [XLEN-1:0] op1, op2;
   logic            haz_src;

`ifdef EX_FORWARD_EN
   localparam bit FwdEn = 1'b1;

   function automatic logic [XLEN-1:0] fwd(
      input logic [4:0]      rs,
      input logic [XLEN-1:0] data
   );
      if (rs == 5'd0)
         return data;
      else if (mem_reg_write && mem_rd == rs)
         return mem_fwd_data;
      else if (wb_reg_write && wb_rd == rs)
         return wb_write_data;
      else
         return data;
   endfunction

   assign op1     = fwd(rs1_q, rs1_data_q);
   assign op2     = fwd(rs2_q, rs2_data_q);
   assign haz_src = mem_read_q;
`else
   localparam bit FwdEn = 1'b0;
   logic unused_fwd;

   assign unused_fwd = ^{mem_reg_write, mem_rd, mem_fwd_data};
   assign op1        = rs1_data_q;
   assign op2        = rs2_data_q;
   assign haz_src    = reg_write_q;
`endif

   // Next-state selection: flush or empty ID gives a bubble, stall holds.
   always_comb begin
      valid_d      = valid_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      rs1_d        = rs1_q;
      rs2_d        = rs2_q;
      rd_d         = rd_q;
      rs1_data_d   = rs1_data_q;
      rs2_data_d   = rs2_data_q;
      imm_d        = imm_q;
      alu_op_d     = alu_op_q;
      alu_src_d    = alu_src_q;
      reg_write_d  = reg_write_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_to_reg_d = mem_to_reg_q;
      if (flush || (!stall && !id_valid)) begin
         valid_d      = 1'b0;
         pc_d         = '0;
         inst_d       = NOP_INST;
         rs1_d        = '0;
         rs2_d        = '0;
         rd_d         = '0;
         rs1_data_d   = '0;
         rs2_data_d   = '0;
         imm_d        = '0;
         alu_op_d     = '0;
         alu_src_d    = 1'b0;
         reg_write_d  = 1'b0;
         mem_read_d   = 1'b0;
         mem_write_d  = 1'b0;
         mem_to_reg_d = 1'b0;
      end else if (stall) begin
         if (FwdEn && wb_reg_write && wb_rd != 5'd0) begin
            if (wb_rd == rs1_q) rs1_data_d = wb_write_data;
            if (wb_rd == rs2_q) rs2_data_d = wb_write_data;
         end
      end else begin
         valid_d      = 1'b1;
         pc_d         = id_pc;
         inst_d       = id_inst;
         rs1_d        = id_rs1;
         rs2_d        = id_rs2;
         rd_d         = id_rd;
         rs1_data_d   = id_rs1_data;
         rs2_data_d   = id_rs2_data;
         imm_d        = id_imm;
         alu_op_d     = id_alu_op;
         alu_src_d    = id_alu_src;
         reg_write_d  = id_reg_write;
         mem_read_d   = id_mem_read;
         mem_write_d  = id_mem_write;
         mem_to_reg_d = id_mem_to_reg;
      end
   end

   // ID/EX register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q      <= 1'b0;
         pc_q         <= '0;
         inst_q       <= NOP_INST;
         rs1_q        <= '0;
         rs2_q        <= '0;
         rd_q         <= '0;
         rs1_data_q   <= '0;
         rs2_data_q   <= '0;
         imm_q        <= '0;
         alu_op_q     <= '0;
         alu_src_q    <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
      end else begin
         valid_q      <= valid_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         rd_q         <= rd_d;
         rs1_data_q   <= rs1_data_d;
         rs2_data_q   <= rs2_data_d;
         imm_q        <= imm_d;
         alu_op_q     <= alu_op_d;
         alu_src_q    <= alu_src_d;
         reg_write_q  <= reg_write_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_to_reg_q <= mem_to_reg_d;
      end
   end

   assign ex_valid        = valid_q;
   assign ex_pc           = pc_q;
   assign ex_inst         = inst_q;
   assign ex_rd           = rd_q;
   assign ex_alu_op       = alu_op_q;
   assign ex_reg_write    = reg_write_q;
   assign ex_mem_read     = mem_read_q;
   assign ex_mem_write    = mem_write_q;
   assign ex_mem_to_reg   = mem_to_reg_q;
   assign ex_alu_in_1     = op1;
   assign ex_alu_in_2     = alu_src_q ? imm_q : op2;
   assign ex_store_data   = op2;
   assign load_use_hazard = reset_n && valid_q && haz_src
                         && rd_q != 5'd0 && id_valid
                         && (rd_q == id_rs1 || rd_q == id_rs2);

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage; expectations follow the
// EX_FORWARD_EN setting of the build.
module tb_id_ex_operand_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        id_valid;
   logic [31:0] id_pc, id_inst;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm;
   logic [1:0]  id_alu_op;
   logic        id_alu_src, id_reg_write, id_mem_read;
   logic        id_mem_write, id_mem_to_reg;
   logic        stall, flush;
   logic        mem_reg_write;
   logic [4:0]  mem_rd;
   logic [31:0] mem_fwd_data;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_write_data;
   logic        ex_valid;
   logic [31:0] ex_pc, ex_inst;
   logic [4:0]  ex_rd;
   logic [1:0]  ex_alu_op;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
   logic [31:0] ex_alu_in_1, ex_alu_in_2, ex_store_data;
   logic        load_use_hazard;

   int errors = 0;
   int checks = 0;

`ifdef EX_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   id_ex_operand_stage dut (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
      .id_pc(id_pc), .id_inst(id_inst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
      .stall(stall), .flush(flush),
      .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
      .mem_fwd_data(mem_fwd_data),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .wb_write_data(wb_write_data),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_inst(ex_inst),
      .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_alu_in_1(ex_alu_in_1), .ex_alu_in_2(ex_alu_in_2),
      .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic id_load(input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic src,
                          input logic [1:0] op, input logic rw,
                          input logic mr, input logic mw);
      id_valid = 1'b1; id_pc = pc; id_inst = pc ^ 32'h00A0_0033;
      id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
      id_alu_src = src; id_alu_op = op; id_reg_write = rw;
      id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = mr;
   endtask

   task automatic clr_fwd();
      mem_reg_write = 1'b0; mem_rd = 5'd0; mem_fwd_data = 32'h0;
      wb_reg_write = 1'b0; wb_rd = 5'd0; wb_write_data = 32'h0;
   endtask

   initial begin
      reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
      clr_fwd();
      id_load($urandom, 5'($urandom), 5'($urandom), 5'($urandom),
              $urandom, $urandom, $urandom, 1'b1, 2'($urandom),
              1'b1, 1'b1, 1'b1);
      step();
      id_rs1 = 5'($urandom); id_rs2 = ex_rd;
      step();
      // reset state, still inside reset
      chk("rst_valid", {31'd0, ex_valid}, 32'd0);
      chk("rst_inst", ex_inst, 32'h00000013);
      chk("rst_ctrl", {28'd0, ex_reg_write, ex_mem_read,
                       ex_mem_write, ex_mem_to_reg}, 32'd0);
      chk("rst_rd_op", {25'd0, ex_rd, ex_alu_op}, 32'd0);
      chk("rst_pc", ex_pc, 32'd0);
      chk("rst_hazard", {31'd0, load_use_hazard}, 32'd0);
      reset_n = 1'b1;

      // MEM forwarding priority over WB, immediate select
      id_load(32'h100, 5'd5, 5'd6, 5'd10, 32'h11, 32'h33,
              32'hFFFFFFF0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
      step();
      chk("load_valid", {31'd0, ex_valid}, 32'd1);
      chk("load_pc", ex_pc, 32'h100);
      chk("load_inst", ex_inst, 32'h100 ^ 32'h00A0_0033);
      chk("load_rd_op", {25'd0, ex_rd, ex_alu_op}, {25'd0, 5'd10, 2'b11});
      mem_reg_write = 1'b1; mem_rd = 5'd5; mem_fwd_data = 32'hAA;
      wb_reg_write = 1'b1; wb_rd = 5'd5; wb_write_data = 32'hBB;
      #1;
      chk("fwd_mem_rs1", ex_alu_in_1, FWD ? 32'hAA : 32'h11);
      mem_reg_write = 1'b0;
      #1;
      chk("fwd_wb_rs1", ex_alu_in_1, FWD ? 32'hBB : 32'h11);
      mem_reg_write = 1'b1; mem_rd = 5'd6; mem_fwd_data = 32'h22;
      wb_rd = 5'd6;
      #1;
      chk("imm_sel", ex_alu_in_2, 32'hFFFFFFF0);
      chk("store_fwd", ex_store_data, FWD ? 32'h22 : 32'h33);
      clr_fwd();

      // rs1 = x0 is never forwarded; register rs2 path
      id_load(32'h104, 5'd0, 5'd6, 5'd11, 32'h11, 32'h33,
              32'h5, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
      step();
      mem_reg_write = 1'b1; mem_rd = 5'd0; mem_fwd_data = 32'hAA;
      wb_reg_write = 1'b1; wb_rd = 5'd0; wb_write_data = 32'hBB;
      #1;
      chk("x0_nofwd", ex_alu_in_1, 32'h11);
      chk("rs2_sel", ex_alu_in_2, 32'h33);
      clr_fwd();

      // load-use: lw x7 in EX
      id_load(32'h108, 5'd2, 5'd0, 5'd7, 32'h0, 32'h0,
              32'h4, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
      step();
      id_load(32'h10C, 5'd1, 5'd7, 5'd8, 32'h0, 32'h0,
              32'h0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
      #1;
      chk("lu_rs2", {31'd0, load_use_hazard}, 32'd1);
      id_rs1 = 5'd7; id_rs2 = 5'd3;
      #1;
      chk("lu_rs1", {31'd0, load_use_hazard}, 32'd1);
      id_valid = 1'b0;
      #1;
      chk("lu_id_invalid", {31'd0, load_use_hazard}, 32'd0);
      // lw with rd=0 in EX
      id_load(32'h110, 5'd2, 5'd0, 5'd0, 32'h0, 32'h0,
              32'h4, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
      step();
      id_rs1 = 5'd0; id_rs2 = 5'd0;
      #1;
      chk("lu_rd0", {31'd0, load_use_hazard}, 32'd0);
      // ALU producer x7 in EX: hazard only without forwarding
      id_load(32'h114, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0,
              32'h0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
      step();
      id_rs1 = 5'd7;
      #1;
      chk("raw_alu", {31'd0, load_use_hazard}, FWD ? 32'd0 : 32'd1);

      // stall refresh over 3 stalled cycles
      id_load(32'h200, 5'd9, 5'd4, 5'd3, 32'h1, 32'h2,
              32'h0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
      step();
      stall = 1'b1;
      id_load(32'h300, 5'd12, 5'd13, 5'd14, 32'h55, 32'h66,
              32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
      step();
      chk("stall_hold_pc", ex_pc, 32'h200);
      wb_reg_write = 1'b1; wb_rd = 5'd9; wb_write_data = 32'h77;
      step();
      clr_fwd();
      step();
      stall = 1'b0;
      #1;
      chk("stall_refresh", ex_alu_in_1, FWD ? 32'h77 : 32'h1);
      chk("stall_hold_rd", {27'd0, ex_rd}, 32'd3);

      // flush wins over stall
      id_load(32'h400, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2,
              32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
      step();
      chk("pre_flush_mw", {31'd0, ex_mem_write}, 32'd1);
      stall = 1'b1; flush = 1'b1;
      step();
      chk("flush_valid", {31'd0, ex_valid}, 32'd0);
      chk("flush_ctrl", {30'd0, ex_reg_write, ex_mem_write}, 32'd0);
      chk("flush_inst", ex_inst, 32'h00000013);
      stall = 1'b0; flush = 1'b0;

      // id_valid=0 loads a bubble
      id_load(32'h500, 5'd1, 5'd2, 5'd6, 32'h1, 32'h2,
              32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      step();
      chk("valid_again", {31'd0, ex_valid}, 32'd1);
      id_valid = 1'b0;
      step();
      chk("bubble_valid", {31'd0, ex_valid}, 32'd0);
      chk("bubble_inst", ex_inst, 32'h00000013);
      chk("bubble_rd", {27'd0, ex_rd}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
